// File: rtl/neuron_accum.sv
// neuron_accum -- weighted-sum accumulator for one neuron.
//
// Multiplies N_INPUTS unsigned Q0.8 activations by signed 8-bit weights.
// It sums the products on top of a signed 16-bit bias. The signed 22-bit
// result is offered on a valid/ready port that feeds the sigmoid stage.
// Products are registered one cycle before they are added. A DRAIN state
// folds in the final product after the last beat.
//
// Optional feature: define SAT_EN to clip every addition to the signed 22-bit
// range and report clipping on o_ovf. Without SAT_EN, additions wrap and
// o_ovf is constant 0.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_bias          start an accumulation (IDLE only), signed bias
//   i_act, i_weight          activation (unsigned) / weight (signed) beat
//   i_in_valid, o_in_ready   beat handshake
//   o_sum, o_sum_valid       signed 22-bit result and its valid
//   i_sum_ready              consumer accepts the result
//   o_ovf                    saturation happened in this accumulation
//   o_busy                   not idle
module neuron_accum #(
    parameter int N_INPUTS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_bias,
    input  logic [7:0]  i_act,
    input  logic [7:0]  i_weight,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [21:0] o_sum,
    output logic        o_sum_valid,
    input  logic        i_sum_ready,
    output logic        o_ovf,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    // 8 bits covers the counter up to 128 for N_INPUTS up to 128.
    localparam logic [7:0] LAST_CNT = 8'(N_INPUTS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [21:0]        r_acc;
    logic [7:0]         r_cnt;
    logic [16:0]        r_prod;
    logic               r_prod_v;
    logic               r_ovf;

    logic               w_beat;
    logic signed [16:0] w_act_s;
    logic signed [16:0] w_wgt_s;
    logic signed [16:0] w_prod;
    logic [21:0]        w_prod_ext;
    logic [21:0]        w_sum;
    logic               w_clip;

    assign w_beat  = (r_state == S_ACCUM) && i_in_valid;

    // 9-bit zero-extended activation times sign-extended weight.
    // The largest product magnitude is 255*128, so 17 bits are exact.
    assign w_act_s = {9'b0, i_act};
    assign w_wgt_s = {{9{i_weight[7]}}, i_weight};
    assign w_prod  = w_act_s * w_wgt_s;

    assign w_prod_ext = {{5{r_prod[16]}}, r_prod};

`ifdef SAT_EN
    logic [22:0] w_wide;
    assign w_wide = {r_acc[21], r_acc} + {w_prod_ext[21], w_prod_ext};

    // The top two bits of the widened sum differ only when the 22-bit add
    // overflowed. Bit 22 then carries the true sign.
    always_comb begin
        w_clip = w_wide[22] ^ w_wide[21];
        w_sum  = w_wide[21:0];
        if (w_clip)
            w_sum = w_wide[22] ? 22'h200000 : 22'h1FFFFF;
    end
`else
    assign w_sum  = r_acc + w_prod_ext;
    // No clipping means r_ovf never sets, so o_ovf stays 0.
    assign w_clip = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_sum_valid = 1'b0;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_ACCUM;
            S_ACCUM: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (r_cnt == LAST_CNT)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT: begin
                o_sum_valid = 1'b1;
                if (i_sum_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_prod_v <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc    <= {{6{i_bias[15]}}, i_bias};
                        r_cnt    <= '0;
                        r_prod_v <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    // Add last cycle's product while the new beat is
                    // multiplied.
                    if (r_prod_v) begin
                        r_acc <= w_sum;
                        if (w_clip) r_ovf <= 1'b1;
                    end
                    if (w_beat) begin
                        r_prod   <= w_prod;
                        r_prod_v <= 1'b1;
                        r_cnt    <= r_cnt + 8'd1;
                    end else begin
                        r_prod_v <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_acc    <= w_sum;
                    r_prod_v <= 1'b0;
                    if (w_clip) r_ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_sum = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: tb/tb_neuron_accum.sv
// Self-checking bench for neuron_accum. It uses directed table vectors on an
// N_INPUTS=16 instance. It adds hand-written sequences for the output hold,
// a mid-accumulation reset, and an N_INPUTS=80 saturation/wrap case.
module tb_neuron_accum;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, sum_ready;
    logic [15:0] bias;
    logic [7:0]  act, weight;
    logic        in_ready, sum_valid, ovf, busy;
    logic [21:0] sum;

    logic        b_rst, b_start, b_in_valid, b_sum_ready;
    logic [15:0] b_bias;
    logic [7:0]  b_act, b_weight;
    logic        b_in_ready, b_sum_valid, b_ovf, b_busy;
    logic [21:0] b_sum;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    neuron_accum #(.N_INPUTS(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias),
        .i_act(act), .i_weight(weight), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_sum(sum), .o_sum_valid(sum_valid),
        .i_sum_ready(sum_ready), .o_ovf(ovf), .o_busy(busy));

    neuron_accum #(.N_INPUTS(80)) dut80 (
        .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_bias(b_bias),
        .i_act(b_act), .i_weight(b_weight), .i_in_valid(b_in_valid),
        .o_in_ready(b_in_ready), .o_sum(b_sum), .o_sum_valid(b_sum_valid),
        .i_sum_ready(b_sum_ready), .o_ovf(b_ovf), .o_busy(b_busy));

    typedef struct {
        logic [15:0] bias;
        logic [7:0]  act;
        logic [7:0]  wgt;
        bit          gap;   // in_valid low on even ACCUM cycles
        logic [21:0] sum;
        bit          ovf;
        int          lat;   // start -> sum_valid cycles
        int          rdy;   // cycles in_ready was high
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input longint a, input longint e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // One accumulation on the N=16 instance with constant act/weight.
    // hold=1 keeps sum_ready low for 5 cycles with start and in_valid high.
    task automatic run_vec(input vec_t v, input bit hold, input string tag);
        int lat, rdy, beats, k;
        start = 1'b1; bias = v.bias; act = v.act; weight = v.wgt;
        @(negedge clk);
        start = 1'b0; lat = 1; rdy = 0; beats = 0; k = 0;
        while (!sum_valid && lat < 200) begin
            in_valid = (beats < 16) && (!v.gap || (k % 2 == 1));
            if (in_ready) rdy++;
            if (in_ready && in_valid) beats++;
            @(negedge clk);
            lat++; k++;
        end
        in_valid = 1'b0;
        chk({tag, " no-timeout"}, longint'(lat < 200), 1);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " ready-cycles"}, rdy, v.rdy);
        chk({tag, " sum"}, sum, v.sum);
        chk({tag, " ovf"}, ovf, v.ovf);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                start = 1'b1; in_valid = 1'b1;
                @(negedge clk);
                chk({tag, " hold valid"}, sum_valid, 1);
                chk({tag, " hold sum"}, sum, v.sum);
                chk({tag, " hold in_ready"}, in_ready, 0);
            end
            start = 1'b0; in_valid = 1'b0;
        end
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk({tag, " busy after xfer"}, busy, 0);
        chk({tag, " valid after xfer"}, sum_valid, 0);
    endtask

    initial begin
        // 16*255*127 = 518160; -32768 + 16*255*(-128) = -555008
        vecs[0] = '{16'h0000, 8'd255, 8'h7F, 1'b0, 22'h07E810, 1'b0, 18, 16};
        vecs[1] = '{16'h8000, 8'd255, 8'h80, 1'b0, 22'h378800, 1'b0, 18, 16};
        vecs[2] = '{16'h0000, 8'd255, 8'h7F, 1'b1, 22'h07E810, 1'b0, 34, 32};
        // 100 + 0
        vecs[3] = '{16'd100,  8'd0,   8'h80, 1'b0, 22'h000064, 1'b0, 18, 16};
        // 32767 + 16 = 32783
        vecs[4] = '{16'h7FFF, 8'd1,   8'h01, 1'b0, 22'h00800F, 1'b0, 18, 16};
        // -1 + 16*128*(-1) = -2049
        vecs[5] = '{16'hFFFF, 8'd128, 8'hFF, 1'b0, 22'h3FF7FF, 1'b0, 18, 16};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; sum_ready = 1'b0;
        bias = '0; act = '0; weight = '0;
        b_rst = 1'b1; b_start = 1'b0; b_in_valid = 1'b0; b_sum_ready = 1'b0;
        b_bias = '0; b_act = '0; b_weight = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset sum_valid", sum_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset ovf", ovf, 0);
        chk("reset busy", busy, 0);
        chk("reset busy80", b_busy, 0);
        rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run_vec(vecs[0], 1'b1, "hold");

        // Reset after 7 accepted beats, then a clean run.
        start = 1'b1; bias = '0; act = 8'd255; weight = 8'h7F;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        repeat (7) @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst sum_valid", sum_valid, 0);
        chk("midrst sum", sum, 0);
        run_vec(vecs[0], 1'b0, "post-rst");

        // N=80: true total 2590800 exceeds 2^21-1.
        begin
            int lat;
            b_start = 1'b1; b_act = 8'd255; b_weight = 8'h7F; b_bias = '0;
            @(negedge clk);
            b_start = 1'b0; b_in_valid = 1'b1; lat = 1;
            while (!b_sum_valid && lat < 300) begin
                if (lat == 81) b_in_valid = 1'b0;
                @(negedge clk);
                lat++;
            end
            b_in_valid = 1'b0;
            chk("n80 no-timeout", longint'(lat < 300), 1);
            chk("n80 latency", lat, 82);
`ifdef SAT_EN
            chk("n80 sum", b_sum, 22'h1FFFFF);
            chk("n80 ovf", b_ovf, 1);
`else
            chk("n80 sum", b_sum, 22'h278850);
            chk("n80 ovf", b_ovf, 0);
`endif
            b_sum_ready = 1'b1;
            @(negedge clk);
            b_sum_ready = 1'b0;
            chk("n80 busy after xfer", b_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
